mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS-32 datapath.
- Consumes opcode[5:0] from the instruction field splitter.
- Sequences fetch / decode / execute / memory / writeback.
- Drives every datapath mux select and write enable, stalls on a memory-ready handshake, and counts retired instructions.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mips_ctrl_outdec.sv | 71 +++++++
 rtl/mips_multicycle_ctrl.sv | 100 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath select codes and the packed control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] ALUSRCB_B       = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: maps the current FSM state (plus the
// memory handshake, for the Mealy fetch strobes) onto every datapath select.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        // Precompute branch target into ALUOut.
        ctrl_o.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemAddr, StAddiExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StRExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUSRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: next-state logic, state register and
// retired-instruction counter. Outputs are held low while reset is asserted.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             illegal;
  ctrl_t            ctrl;

  always_comb begin
    state_d = StFetch;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StRExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiExec;
          default:      illegal = 1'b1;
        endcase
      end
      StMemAddr:  state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:    state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr: begin
        state_d = mem_ready ? StFetch : StMemWr;
        retire  = mem_ready;
      end
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StMemWb, StRWb, StBranch, StJump, StAddiWb: retire = 1'b1;
      default:    state_d = StFetch;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Gate with rst_n so strobes drop immediately, before any clock edge.
  assign pc_write      = rst_n & ctrl.pc_write;
  assign pc_write_cond = rst_n & ctrl.pc_write_cond;
  assign pc_source     = rst_n ? ctrl.pc_source : 2'b00;
  assign i_or_d        = rst_n & ctrl.i_or_d;
  assign mem_read      = rst_n & ctrl.mem_read;
  assign mem_write     = rst_n & ctrl.mem_write;
  assign ir_write      = rst_n & ctrl.ir_write;
  assign reg_dst       = rst_n & ctrl.reg_dst;
  assign mem_to_reg    = rst_n & ctrl.mem_to_reg;
  assign reg_write     = rst_n & ctrl.reg_write;
  assign alu_src_a     = rst_n & ctrl.alu_src_a;
  assign alu_src_b     = rst_n ? ctrl.alu_src_b : 2'b00;
  assign alu_op        = rst_n ? ctrl.alu_op : 2'b00;
  assign illegal_op    = rst_n & illegal;
  assign state_o       = rst_n ? state_q : 4'd0;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver queues the expected
// state/count per cycle, a negedge monitor compares the full control word.
module tb_mips_multicycle_ctrl;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
  localparam int S_REX = 6, S_RWB = 7, S_BR = 8, S_J = 9, S_AEX = 10, S_AWB = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state_o;
  logic [31:0] instr_count;

  logic        b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rdst, b_m2r, b_rw, b_sa, b_ill;
  logic [1:0]  b_psrc, b_sb, b_aop;
  logic [3:0]  b_state;
  logic [3:0]  b_cnt;

  logic [16:0] act_word;

  mips_multicycle_ctrl #(.CNT_W(32)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .state_o       (state_o),
    .instr_count   (instr_count)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (b_pcw),
    .pc_write_cond (b_pcwc),
    .pc_source     (b_psrc),
    .i_or_d        (b_iord),
    .mem_read      (b_mr),
    .mem_write     (b_mw),
    .ir_write      (b_irw),
    .reg_dst       (b_rdst),
    .mem_to_reg    (b_m2r),
    .reg_write     (b_rw),
    .alu_src_a     (b_sa),
    .alu_src_b     (b_sb),
    .alu_op        (b_aop),
    .illegal_op    (b_ill),
    .state_o       (b_state),
    .instr_count   (b_cnt)
  );

  always #5 clk = ~clk;

  assign act_word = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

  typedef struct {
    int         st;
    logic [5:0] op;
    logic       rdy;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference control word, written straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op, input logic rdy);
    logic       pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic       rdst = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] psrc = 0, sb = 0, aop = 0;
    case (st)
      S_F:   begin mr = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
      S_D:   begin
        sb  = 2'd3;
        ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
      end
      S_MA:  begin sa = 1; sb = 2'd2; end
      S_MRD: begin mr = 1; iord = 1; end
      S_MWB: begin rw = 1; m2r = 1; end
      S_MWR: begin mw = 1; iord = 1; end
      S_REX: begin sa = 1; aop = 2'd2; end
      S_RWB: begin rw = 1; rdst = 1; end
      S_BR:  begin sa = 1; aop = 2'd1; pcwc = 1; psrc = 2'd1; end
      S_J:   begin pcw = 1; psrc = 2'd2; end
      S_AEX: begin sa = 1; sb = 2'd2; end
      S_AWB: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, psrc, iord, mr, mw, irw, rdst, m2r, rw, sa, sb, aop, ill};
  endfunction

  task automatic step(input logic [5:0] op, input logic rdy, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    e.st  = st;
    e.op  = op;
    e.rdy = rdy;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", 32'(state_o), 32'(e.st));
      chk("ctrl_word", 32'(act_word), 32'(exp_ctrl(e.st, e.op, e.rdy)));
      chk("instr_count", instr_count, 32'(e.cnt));
      chk("instr_count_w4", 32'(b_cnt), 32'(e.cnt % 16));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctrl_zero", 32'(act_word), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    #10 rst_n = 1'b1;  // released between edges with mem_ready low

    // R-type: 0,1,6,7
    step(6'h00, 1, S_F); step(6'h00, 1, S_D); step(6'h00, 1, S_REX); step(6'h00, 1, S_RWB);
    cnt++;
    // lw with two stall cycles in MEM_RD: 7 cycles
    step(6'h23, 1, S_F); step(6'h23, 1, S_D); step(6'h23, 1, S_MA);
    step(6'h23, 0, S_MRD); step(6'h23, 0, S_MRD); step(6'h23, 1, S_MRD); step(6'h23, 1, S_MWB);
    cnt++;
    // sw, beq, j
    step(6'h2B, 1, S_F); step(6'h2B, 1, S_D); step(6'h2B, 1, S_MA); step(6'h2B, 1, S_MWR);
    cnt++;
    step(6'h04, 1, S_F); step(6'h04, 1, S_D); step(6'h04, 1, S_BR);
    cnt++;
    step(6'h02, 1, S_F); step(6'h02, 1, S_D); step(6'h02, 1, S_J);
    cnt++;
    // unsupported opcode: pulse in DECODE, no retirement
    step(6'h3F, 1, S_F); step(6'h3F, 1, S_D);
    // addi with one fetch stall
    step(6'h08, 0, S_F); step(6'h08, 1, S_F); step(6'h08, 1, S_D);
    step(6'h08, 1, S_AEX); step(6'h08, 1, S_AWB);
    cnt++;
    // sw stalled in MEM_WR, then asynchronous reset
    step(6'h2B, 1, S_F); step(6'h2B, 1, S_D); step(6'h2B, 1, S_MA); step(6'h2B, 0, S_MWR);
    @(negedge clk);
    #1;
    chk("mw_before_rst", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mw_async_drop", 32'(mem_write), 32'd0);
    chk("rst_mid_ctrl", 32'(act_word), 32'd0);
    chk("rst_mid_state", 32'(state_o), 32'd0);
    chk("rst_mid_count", instr_count, 32'd0);
    chk("rst_mid_count4", 32'(b_cnt), 32'd0);
    cnt = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // 16 addi: 4-bit counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(6'h08, 1, S_F); step(6'h08, 1, S_D); step(6'h08, 1, S_AEX); step(6'h08, 1, S_AWB);
      cnt++;
    end
    step(6'h00, 0, S_F);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
